adder_seq_ctrl: RTL and testbench
=================================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 14: width of the signed fixed-point adder result and final output.
REQ-002 The block SHALL have parameter PASS_W, default 6: width of the pass-count input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin one output-pixel job; honoured only in IDLE.
REQ-006 The block SHALL have port num_passes, input, PASS_W bits: unsigned count of adder-tree passes per job, sampled on the accepted start.
REQ-007 The block SHALL have port abort, input, 1 bit: cancel the current job.
REQ-008 The block SHALL have port win_valid, input, 1 bit: the upstream window buffer has a 27-operand window ready.
REQ-009 The block SHALL have port win_ready, output, 1 bit: the controller accepts a window this cycle.
REQ-010 The block SHALL have port adder_valid_in, output, 1 bit: drives the adder tree's data_valid_in.
REQ-011 The block SHALL have port adder_end_flag, output, 1 bit: drives the adder tree's end_flag.
REQ-012 The block SHALL have port adder_sum, input, DATA_WIDTH bits, signed: the adder tree's sum_output.
REQ-013 The block SHALL have port adder_valid_out, input, 1 bit: the adder tree's data_valid_out.
REQ-014 The block SHALL have port out_data, output, DATA_WIDTH bits, signed: the accumulated job result.
REQ-015 The block SHALL have port out_valid, output, 1 bit: one-cycle strobe qualifying out_data.
REQ-016 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a job, whether completed or aborted.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN and FINISH.
REQ-019 Transitions:
- IDLE -> ISSUE on start, when num_passes != 0.
- ISSUE -> DRAIN after the num_passes-th window handshake.
- DRAIN -> FINISH on the cycle the num_passes-th adder result is accumulated.
- FINISH -> IDLE unconditionally.
REQ-020 In IDLE, a start with num_passes == 0 SHALL go directly to FINISH: no adder traffic, out_valid stays 0, done pulses.
REQ-021 win_ready SHALL equal 1 only in ISSUE while issued < num_passes; a handshake is win_valid & win_ready.
REQ-022 adder_valid_in SHALL be a registered copy of the handshake, asserted exactly one cycle after each handshake.
REQ-023 Issued and received counters (PASS_W bits each) SHALL clear on the accepted start; neither SHALL ever exceed num_passes.
REQ-024 Accumulator width SHALL be DATA_WIDTH+PASS_W, signed.
- Cleared on the accepted start.
- Adds sign-extended adder_sum on each adder_valid_out while in ISSUE or DRAIN and received < num_passes.
REQ-025 adder_valid_out SHALL be ignored in IDLE and FINISH, and beyond num_passes results.
REQ-026 On entry to FINISH after a completed job: out_data = accumulator reduced to DATA_WIDTH per REQ-032; out_valid = 1 and done = 1 for exactly that cycle.
- Latency: out_valid is 1 cycle after the last accumulated adder_valid_out.
REQ-027 out_data SHALL hold its value until the next completed job.
REQ-028 abort in ISSUE or DRAIN SHALL, on the next cycle:
- pulse adder_end_flag for 1 cycle;
- clear the counters and accumulator;
- go to FINISH with out_valid = 0 and done = 1.
REQ-029 abort SHALL take priority over a simultaneous handshake or adder result, neither of which is counted; abort in IDLE or FINISH SHALL be ignored.
REQ-030 start while busy SHALL be ignored.

Reset
REQ-031 While reset = 1, on each clock edge:
- the FSM SHALL go to IDLE and the counters and accumulator SHALL clear;
- out_data SHALL be 0, and out_valid, done, win_ready, adder_valid_in and adder_end_flag SHALL be 0;
- busy SHALL be 0;
- reset during a job SHALL discard the job with no done pulse.

Configuration
REQ-032 Macro ACC_SAT_EN SHALL select how the accumulator is reduced to DATA_WIDTH for out_data.
- Defined: clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: take the low DATA_WIDTH bits (two's-complement wrap).

Verification
REQ-033 The bench SHALL cover these scenarios:
- num_passes=3; win_valid held 1; adder returns 100, -20, 5 -> 3 adder_valid_in pulses, out_data=85, out_valid and done 1 cycle each.
- num_passes=4; win_valid toggling 1,0,1,0... -> exactly 4 handshakes and 4 adder_valid_in pulses; win_ready drops after the 4th.
- num_passes=2; adder_sum 8000 twice -> out_data 8191 with ACC_SAT_EN; 16000 truncated to 14 bits = -384 without.
- abort after 1 result of num_passes=5 -> adder_end_flag 1 cycle, done=1, out_valid=0, next job result unaffected.
- start with num_passes=0 -> done next cycle, no adder_valid_in, no out_valid.
- reset asserted mid-DRAIN -> all outputs 0 next cycle, busy=0, no done pulse; late adder_valid_out ignored.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Sequencing controller for a 27-operand adder tree: issues num_passes windows, accumulates
// the adder results and emits one output pixel. Define ACC_SAT_EN to saturate instead of wrap.
module adder_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned PASS_W     = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic        [PASS_W-1:0]     num_passes,
  input  logic                         abort,
  input  logic                         win_valid,
  output logic                         win_ready,
  output logic                         adder_valid_in,
  output logic                         adder_end_flag,
  input  logic signed [DATA_WIDTH-1:0] adder_sum,
  input  logic                         adder_valid_out,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned AccW = DATA_WIDTH + PASS_W;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

  state_e                      state_q, state_d;
  logic        [PASS_W-1:0]    issued_q, issued_d;
  logic        [PASS_W-1:0]    received_q, received_d;
  logic        [PASS_W-1:0]    npass_q, npass_d;
  logic signed [AccW-1:0]      acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic                        done_q, done_d;
  logic                        avi_q, avi_d;
  logic                        end_flag_q, end_flag_d;

  logic                        hs, acc_en, last_issue, last_recv, active;
  logic signed [AccW-1:0]      acc_sum;
  logic signed [DATA_WIDTH-1:0] acc_red;

  always_comb begin
    active     = (state_q == StIssue) || (state_q == StDrain);
    hs         = win_valid && win_ready;
    acc_en     = adder_valid_out && active && (received_q < npass_q) && !abort;
    last_issue = hs && (issued_q == npass_q - PASS_W'(1));
    last_recv  = acc_en && (received_q == npass_q - PASS_W'(1));
    acc_sum    = acc_q + {{PASS_W{adder_sum[DATA_WIDTH-1]}}, adder_sum};
  end

`ifdef ACC_SAT_EN
  localparam logic signed [AccW-1:0] AccMax = {{(PASS_W + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [AccW-1:0] AccMin = {{(PASS_W + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  always_comb begin
    if (acc_sum > AccMax) begin
      acc_red = AccMax[DATA_WIDTH-1:0];
    end else if (acc_sum < AccMin) begin
      acc_red = AccMin[DATA_WIDTH-1:0];
    end else begin
      acc_red = acc_sum[DATA_WIDTH-1:0];
    end
  end
`else
  assign acc_red = acc_sum[DATA_WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (num_passes == '0) ? StFinish : StIssue;
      end
      StIssue: begin
        if (abort || last_recv) begin
          state_d = StFinish;
        end else if (last_issue) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (abort || last_recv) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state; abort wins over any same-cycle handshake or result.
  always_comb begin
    issued_d    = issued_q;
    received_d  = received_q;
    npass_d     = npass_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    avi_d       = 1'b0;
    end_flag_d  = 1'b0;
    if (state_q == StIdle) begin
      if (start) begin
        npass_d    = num_passes;
        issued_d   = '0;
        received_d = '0;
        acc_d      = '0;
        done_d     = (num_passes == '0);
      end
    end else if (active) begin
      if (abort) begin
        issued_d   = '0;
        received_d = '0;
        acc_d      = '0;
        end_flag_d = 1'b1;
        done_d     = 1'b1;
      end else begin
        if (hs) begin
          issued_d = issued_q + PASS_W'(1);
          avi_d    = 1'b1;
        end
        if (acc_en) begin
          received_d = received_q + PASS_W'(1);
          acc_d      = acc_sum;
        end
        if (last_recv) begin
          out_data_d  = acc_red;
          out_valid_d = 1'b1;
          done_d      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q    <= '0;
      received_q  <= '0;
      npass_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      avi_q       <= 1'b0;
      end_flag_q  <= 1'b0;
    end else begin
      issued_q    <= issued_d;
      received_q  <= received_d;
      npass_q     <= npass_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      avi_q       <= avi_d;
      end_flag_q  <= end_flag_d;
    end
  end

  always_comb begin
    busy           = (state_q != StIdle);
    win_ready      = (state_q == StIssue) && (issued_q < npass_q);
    adder_valid_in = avi_q;
    adder_end_flag = end_flag_q;
    out_data       = out_data_q;
    out_valid      = out_valid_q;
    done           = done_q;
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed self-checking bench for adder_seq_ctrl; the bench plays the adder tree by hand.
module tb_adder_seq_ctrl;

  localparam int unsigned DW = 14;
  localparam int unsigned PW = 6;

  logic                 clk = 1'b0;
  logic                 reset, start, abort, win_valid, adder_valid_out;
  logic        [PW-1:0] num_passes;
  logic signed [DW-1:0] adder_sum;
  logic                 win_ready, adder_valid_in, adder_end_flag, out_valid, busy, done;
  logic signed [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int avi_cnt = 0, done_cnt = 0, ov_cnt = 0, ef_cnt = 0, hs_cnt = 0;
  int b_avi, b_done, b_ov, b_ef, b_hs;

  adder_seq_ctrl #(.DATA_WIDTH(DW), .PASS_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .num_passes     (num_passes),
    .abort          (abort),
    .win_valid      (win_valid),
    .win_ready      (win_ready),
    .adder_valid_in (adder_valid_in),
    .adder_end_flag (adder_end_flag),
    .adder_sum      (adder_sum),
    .adder_valid_out(adder_valid_out),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (adder_valid_in)        avi_cnt  <= avi_cnt + 1;
    if (done)                  done_cnt <= done_cnt + 1;
    if (out_valid)             ov_cnt   <= ov_cnt + 1;
    if (adder_end_flag)        ef_cnt   <= ef_cnt + 1;
    if (win_valid && win_ready) hs_cnt  <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_avi = avi_cnt; b_done = done_cnt; b_ov = ov_cnt; b_ef = ef_cnt; b_hs = hs_cnt;
  endtask

  // Accept a job and hand over n windows back-to-back; ends in DRAIN.
  task automatic run_issue(input int n);
    start = 1'b1; num_passes = PW'(n); win_valid = 1'b1;
    tick();
    start = 1'b0;
    repeat (n) tick();
    win_valid = 1'b0;
  endtask

  task automatic feed(input int s);
    adder_valid_out = 1'b1; adder_sum = DW'(s);
    tick();
    adder_valid_out = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; win_valid = 1'b0;
    adder_valid_out = 1'b0; adder_sum = '0; num_passes = '0;
    tick(); tick();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_ready", win_ready, 0);
    chk("rst_avi", adder_valid_in, 0);
    chk("rst_end_flag", adder_end_flag, 0);
    reset = 1'b0;
    tick();

    // Three passes, results 100, -20, 5.
    snap();
    run_issue(3);
    chk("s1_win_ready_drop", win_ready, 0);
    chk("s1_busy", busy, 1);
    feed(100);
    feed(-20);
    feed(5);
    chk("s1_out_data", out_data, 85);
    chk("s1_out_valid", out_valid, 1);
    chk("s1_done", done, 1);
    tick();
    chk("s1_out_valid_low", out_valid, 0);
    chk("s1_done_low", done, 0);
    chk("s1_idle", busy, 0);
    chk("s1_hold", out_data, 85);
    chk("s1_avi_pulses", avi_cnt - b_avi, 3);
    chk("s1_done_pulses", done_cnt - b_done, 1);
    chk("s1_ov_pulses", ov_cnt - b_ov, 1);

    // Four passes with a toggling window source.
    snap();
    start = 1'b1; num_passes = 4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      win_valid = (i % 2 == 0);
      tick();
    end
    win_valid = 1'b0;
    chk("s2_handshakes", hs_cnt - b_hs, 4);
    chk("s2_avi_pulses", avi_cnt - b_avi, 4);
    chk("s2_win_ready_drop", win_ready, 0);
    feed(1);
    feed(2);
    feed(3);
    adder_valid_out = 1'b1; adder_sum = 4;
    tick();
    chk("s2_out_data", out_data, 10);
    chk("s2_out_valid", out_valid, 1);
    adder_sum = 1000;
    tick();
    tick();
    adder_valid_out = 1'b0;
    chk("s2_extra_ignored", out_data, 10);
    chk("s2_ov_pulses", ov_cnt - b_ov, 1);

    // Overflowing sum; a start while busy must be ignored.
    run_issue(2);
    start = 1'b1; num_passes = 1;
    feed(8000);
    feed(8000);
    start = 1'b0;
`ifdef ACC_SAT_EN
    chk("s3_sat", out_data, 8191);
`else
    chk("s3_wrap", out_data, -384);
`endif
    chk("s3_out_valid", out_valid, 1);
    tick();

    // Abort after one result; simultaneous result must not count.
    snap();
    run_issue(5);
    feed(7);
    abort = 1'b1; adder_valid_out = 1'b1; adder_sum = 50;
    tick();
    abort = 1'b0; adder_valid_out = 1'b0;
    chk("s4_end_flag", adder_end_flag, 1);
    chk("s4_done", done, 1);
    chk("s4_out_valid", out_valid, 0);
`ifdef ACC_SAT_EN
    chk("s4_hold", out_data, 8191);
`else
    chk("s4_hold", out_data, -384);
`endif
    tick();
    chk("s4_end_flag_low", adder_end_flag, 0);
    chk("s4_idle", busy, 0);
    chk("s4_ef_pulses", ef_cnt - b_ef, 1);
    run_issue(1);
    feed(33);
    chk("s4_next_job", out_data, 33);
    tick();

    // Zero-pass job.
    snap();
    start = 1'b1; num_passes = 0;
    tick();
    start = 1'b0;
    chk("s5_done", done, 1);
    chk("s5_out_valid", out_valid, 0);
    tick();
    chk("s5_idle", busy, 0);
    chk("s5_no_avi", avi_cnt - b_avi, 0);
    chk("s5_no_ov", ov_cnt - b_ov, 0);

    // Reset in the middle of DRAIN.
    run_issue(3);
    feed(10);
    snap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("s6_out_data", out_data, 0);
    chk("s6_busy", busy, 0);
    chk("s6_done", done, 0);
    chk("s6_end_flag", adder_end_flag, 0);
    adder_valid_out = 1'b1; adder_sum = 99;
    tick();
    tick();
    adder_valid_out = 1'b0;
    chk("s6_late_result", out_data, 0);
    chk("s6_out_valid", out_valid, 0);
    chk("s6_no_done", done_cnt - b_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
